// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core constants for the RV32I front end
package core_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous DEPTH-entry FIFO holding fetched {pc, instr} pairs
//   clk, reset     : clock, synchronous active-low reset
//   clear          : drop all entries (wins over push/pop)
//   push/push_data : write one entry
//   pop            : advance head (ignored when empty)
//   head           : current head entry
//   count/empty    : occupancy
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [AW:0]      count,
    output logic             empty
);
    import core_pkg::*;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;

    // One extra pointer bit distinguishes full from empty; pointers wrap naturally.
    assign count = wr_ptr - rd_ptr;
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

    // Request throttling upstream keeps pushes away from a full FIFO.
    assert property (@(posedge clk) disable iff (!reset) !(push && full && !clear));

endmodule

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - instruction fetch front end: PC, imem requests, fetch FIFO, IF/ID register
//   clk, reset            : clock, synchronous active-low reset
//   stallF/stallD/FlushD  : hazard unit controls
//   PcSrcE/PCTargetE      : Execute-stage redirect
//   imem_req/imem_addr    : one-word request per cycle
//   imem_rvalid/rdata     : in-order responses
//   InstrD/PCD/PCPlus4D/validD : IF/ID register
//   Optional macro FETCH_BYPASS_EN: accepted response loads IF/ID directly when FIFO is empty.
module fetch_buffer #(
    parameter int              XLEN     = core_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = core_pkg::DEFAULT_RESET_PC,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stallF,
    input  logic            stallD,
    input  logic            FlushD,
    input  logic            PcSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            validD
);
    import core_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   resp_pc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     discard;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic [2*XLEN-1:0] head;
    logic [XLEN-1:0]   head_pc;
    logic [XLEN-1:0]   head_instr;
    logic              issue;
    logic              accept;
    logic              bypass;
    logic              push;
    logic              pop;

    // Credit: every word either in flight or buffered holds one FIFO slot,
    // so a response can never find the FIFO full. Gated by reset so the bus is idle in reset.
    assign issue = reset && !stallF && !PcSrcE &&
                   (({1'b0, outstanding} + {1'b0, fifo_count}) < (CW+1)'(DEPTH));
    assign imem_req  = issue;
    assign imem_addr = pc;

    // Responses that belong to a squashed path are dropped, as is any arriving on the redirect cycle.
    assign accept = imem_rvalid && !PcSrcE && (discard == '0);

`ifdef FETCH_BYPASS_EN
    assign bypass = accept && fifo_empty && !stallD && !FlushD;
`else
    assign bypass = 1'b0;
`endif

    assign push = accept && !bypass;
    assign pop  = !FlushD && !stallD && !fifo_empty;
    assign {head_pc, head_instr} = head;

    fetch_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (PcSrcE),
        .push      (push),
        .push_data ({resp_pc, imem_rdata}),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding + CW'(issue) - CW'(imem_rvalid);
            if (PcSrcE) begin
                pc      <= PCTargetE;
                resp_pc <= PCTargetE;
                // Everything still in flight after this cycle is from the old path.
                discard <= outstanding - CW'(imem_rvalid);
            end else begin
                if (issue)
                    pc <= pc + XLEN'(4);
                if (accept)
                    resp_pc <= resp_pc + XLEN'(4);
                if (imem_rvalid && (discard != '0))
                    discard <= discard - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || FlushD) begin
            InstrD   <= XLEN'(NOP_INSTR);
            PCD      <= '0;
            PCPlus4D <= '0;
            validD   <= 1'b0;
        end else if (!stallD) begin
            if (!fifo_empty) begin
                InstrD   <= head_instr;
                PCD      <= head_pc;
                PCPlus4D <= head_pc + XLEN'(4);
                validD   <= 1'b1;
`ifdef FETCH_BYPASS_EN
            end else if (accept) begin
                InstrD   <= imem_rdata;
                PCD      <= resp_pc;
                PCPlus4D <= resp_pc + XLEN'(4);
                validD   <= 1'b1;
`endif
            end else begin
                InstrD   <= XLEN'(NOP_INSTR);
                PCD      <= '0;
                PCPlus4D <= '0;
                validD   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb/tb_fetch_buffer.sv - self-checking bench for fetch_buffer with imem model and fetch-order scoreboard
module tb_fetch_buffer;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        stallF, stallD, FlushD, PcSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        validD;

    fetch_buffer #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .stallF      (stallF),
        .stallD      (stallD),
        .FlushD      (FlushD),
        .PcSrcE      (PcSrcE),
        .PCTargetE   (PCTargetE),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D),
        .validD      (validD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        mq[$];
    int          tests, fails, cyc, last_due;
    int          lat_min, lat_max;
    logic [31:0] exp_pc, exp_req_addr;
    logic        h_valid;
    logic [31:0] h_instr, h_pc;
    int          delivered, first_valid, mark, guard;
    logic        last_req;
    logic [31:0] last_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive the memory response, check the request side, clock, check IF/ID.
    task automatic step();
        req_t r;
        int   due;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end
        #1;
        last_req  = imem_req;
        last_addr = imem_addr;
        if (!reset || stallF || PcSrcE)
            check("req_blocked", 32'(imem_req), 32'd0);
        if (imem_req === 1'b1) begin
            check("imem_addr", imem_addr, exp_req_addr);
            due = cyc + $urandom_range(lat_min, lat_max);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            r.addr = imem_addr;
            r.due  = due;
            mq.push_back(r);
            check("outstanding_le_depth", 32'(mq.size() <= DEPTH), 32'd1);
        end
        if (!reset)                exp_req_addr = RESET_PC;
        else if (PcSrcE)           exp_req_addr = PCTargetE;
        else if (imem_req === 1'b1) exp_req_addr = exp_req_addr + 32'd4;

        @(posedge clk);
        #1;
        cyc++;

        if (!reset) begin
            mq.delete();
            last_due = cyc;
        end
        if (!reset || FlushD) begin
            check("flush_validD", 32'(validD), 32'd0);
            check("flush_InstrD", InstrD, NOP);
            check("flush_PCD", PCD, 32'd0);
            check("flush_PCPlus4D", PCPlus4D, 32'd0);
            h_valid = 1'b0; h_instr = NOP; h_pc = 32'd0;
            if (!reset)      exp_pc = RESET_PC;
            else if (PcSrcE) exp_pc = PCTargetE;
        end else if (stallD) begin
            check("hold_validD", 32'(validD), 32'(h_valid));
            check("hold_InstrD", InstrD, h_instr);
            check("hold_PCD", PCD, h_pc);
        end else if (validD === 1'b1) begin
            check("seq_PCD", PCD, exp_pc);
            check("seq_InstrD", InstrD, mem_word(exp_pc));
            check("seq_PCPlus4D", PCPlus4D, exp_pc + 32'd4);
            h_valid = 1'b1; h_instr = mem_word(exp_pc); h_pc = exp_pc;
            exp_pc = exp_pc + 32'd4;
            delivered++;
            if (first_valid < 0) first_valid = cyc;
        end else begin
            check("bubble_validD", 32'(validD), 32'd0);
            check("bubble_InstrD", InstrD, NOP);
            h_valid = 1'b0; h_instr = NOP; h_pc = 32'd0;
        end
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0; last_due = 0;
        lat_min = 1; lat_max = 1;
        exp_pc = RESET_PC; exp_req_addr = RESET_PC;
        h_valid = 1'b0; h_instr = NOP; h_pc = 32'd0;
        delivered = 0; first_valid = -1;
        reset = 1'b0; stallF = 1'b0; stallD = 1'b0; FlushD = 1'b0; PcSrcE = 1'b0;
        PCTargetE = 32'h0; imem_rvalid = 1'b0; imem_rdata = 32'h0;

        // Reset state
        step(); step();
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_imem_addr", imem_addr, 32'h0000_0000);
        check("rst_InstrD", InstrD, 32'h0000_0013);
        check("rst_validD", 32'(validD), 32'd0);

        // Latency-1 streaming from reset
        reset = 1'b1;
        mark = cyc;
        first_valid = -1;
        delivered = 0;
        step();
        check("first_req", 32'(last_req), 32'd1);
        check("first_addr", last_addr, 32'h0000_0000);
        step();
        check("second_addr", last_addr, 32'h0000_0004);
        for (int i = 0; i < 10; i++) step();
`ifdef FETCH_BYPASS_EN
        check("first_valid_edge", 32'(first_valid - mark), 32'd2);
`else
        check("first_valid_edge", 32'(first_valid - mark), 32'd3);
`endif
        check("stream_count", 32'(delivered >= 7), 32'd1);

        // Stall with two requests outstanding
        lat_min = 3; lat_max = 3;
        guard = 0;
        while (mq.size() != 2 && guard < 20) begin step(); guard++; end
        check("two_outstanding_b", 32'(mq.size()), 32'd2);
        stallF = 1'b1; stallD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_no_req", 32'(last_req), 32'd0);
        end
        stallF = 1'b0; stallD = 1'b0;
        mark = delivered;
        for (int i = 0; i < 15; i++) step();
        check("post_stall_progress", 32'(delivered - mark >= 2), 32'd1);

        // Redirect with two outstanding
        lat_min = 2; lat_max = 2;
        guard = 0;
        while (mq.size() != 2 && guard < 20) begin step(); guard++; end
        check("two_outstanding_c", 32'(mq.size()), 32'd2);
        PcSrcE = 1'b1; FlushD = 1'b1; PCTargetE = 32'h0000_0100;
        step();
        PcSrcE = 1'b0; FlushD = 1'b0;
        guard = 0;
        do begin step(); guard++; end while (last_req !== 1'b1 && guard < 10);
        check("redirect_addr", last_addr, 32'h0000_0100);
        guard = 0;
        while (validD !== 1'b1 && guard < 20) begin step(); guard++; end
        check("redirect_PCD", PCD, 32'h0000_0100);
        check("redirect_InstrD", InstrD, 32'h1357_9ADF);

        // Flush beats stall
        FlushD = 1'b1; stallD = 1'b1;
        step();
        check("flush_stall_InstrD", InstrD, 32'h0000_0013);
        check("flush_stall_validD", 32'(validD), 32'd0);
        FlushD = 1'b0; stallD = 1'b0;

        // PC wrap across 2^32
        lat_min = 1; lat_max = 1;
        PcSrcE = 1'b1; FlushD = 1'b1; PCTargetE = 32'hFFFF_FFF8;
        step();
        PcSrcE = 1'b0; FlushD = 1'b0;
        guard = 0;
        while (!(validD === 1'b1 && PCD === 32'hFFFF_FFFC) && guard < 30) begin step(); guard++; end
        check("wrap_PCD", PCD, 32'hFFFF_FFFC);
        check("wrap_PCPlus4D", PCPlus4D, 32'h0000_0000);
        for (int i = 0; i < 6; i++) step();

        // Reset with a full FIFO
        stallD = 1'b1;
        for (int i = 0; i < 8; i++) step();
        stallD = 1'b0; reset = 1'b0;
        step();
        check("midrst_validD", 32'(validD), 32'd0);
        check("midrst_InstrD", InstrD, 32'h0000_0013);
        check("midrst_imem_addr", imem_addr, 32'h0000_0000);
        check("midrst_imem_req", 32'(imem_req), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) step();

        // Random latency, stalls, flushes and redirects
        lat_min = 1; lat_max = 4;
        mark = delivered;
        for (int i = 0; i < 10000; i++) begin
            stallF = ($urandom_range(0, 4) == 0);
            stallD = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 39) == 0) begin
                PcSrcE = 1'b1; FlushD = 1'b1;
                PCTargetE = $urandom & 32'h0000_FFFC;
            end else begin
                PcSrcE = 1'b0;
                FlushD = ($urandom_range(0, 49) == 0);
            end
            step();
        end
        check("random_progress", 32'(delivered - mark > 1000), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction-fetch front end for the pipelined RV32I core. Owns the PC, issues in-order requests to instruction memory, buffers returned words in a small FIFO, and drives the IF/ID pipeline register. It is the consumer of the hazard unit's stallF/stallD/FlushD controls and of the Execute-stage branch redirect (PcSrcE/PCTargetE).

## Interface
- XLEN, 32, address/instruction width
- RESET_PC, 32'h0000_0000, PC after reset
- DEPTH, 2, FIFO entries and maximum outstanding requests (power of 2, ≥2)

- clk  in  1  clock
- reset  in  1  synchronous, active-low
- stallF  in  1  freeze request issue and PC advance
- stallD  in  1  hold IF/ID register
- FlushD  in  1  clear IF/ID register to bubble
- PcSrcE  in  1  branch/jump taken in Execute
- PCTargetE  in  XLEN  redirect target
- imem_req  out  1  request valid (one word per cycle)
- imem_addr  out  XLEN  request address
- imem_rvalid  in  1  response valid; in order, ≥1 cycle after request
- imem_rdata  in  XLEN  response word
- InstrD  out  XLEN  instruction in Decode
- PCD  out  XLEN  PC of InstrD
- PCPlus4D  out  XLEN  PCD + 4
- validD  out  1  InstrD is real (0 = bubble)

## Operation
- Reset values: PC=RESET_PC, imem_req=0, imem_addr=RESET_PC, InstrD=32'h0000_0013 (NOP), PCD=0, PCPlus4D=0, validD=0, FIFO empty, outstanding=0, discard=0.
- imem_req = !stallF & !PcSrcE & (outstanding + fifo_count < DEPTH); imem_addr = PC. On issue: PC ← PC+4 (mod 2^XLEN), outstanding+1.
- Each response: outstanding−1. If discard>0: dropped, discard−1. Else pushed to FIFO with its PC (FIFO stores {PC, instr}; PC tracked by a separate response-PC register advanced per accepted response).
- Redirect (PcSrcE=1): PC ← PCTargetE; response-PC ← PCTargetE; FIFO cleared; discard ← outstanding after this cycle's response is counted; any response in that cycle dropped; no request that cycle.
- IF/ID register, priority: FlushD → load NOP, validD=0, PCD/PCPlus4D=0; else stallD → hold; else FIFO non-empty → pop head into InstrD/PCD, PCPlus4D=PCD+4, validD=1; else → NOP bubble, validD=0.
- Overflow impossible by construction; a push to a full FIFO is an assertion failure.

## Timing
- Without bypass: request cycle N, response cycle N+k (k≥1), FIFO write N+k, IF/ID valid at N+k+1 edge → InstrD visible cycle N+k+2 earliest... precisely: response edge writes FIFO, next edge loads IF/ID; fetch-to-Decode = k+2 edges.
- With bypass (see Configuration): k+1 edges.
- Redirect takes effect at the clock edge of the PcSrcE cycle; first request to PCTargetE issues the following cycle.
- Simultaneous: PcSrcE+stallF → redirect applied, issue resumes when stallF=0. PcSrcE+imem_rvalid → response dropped. FlushD+stallD → flush wins. Pop and push same cycle → count unchanged.
- Reset asserted mid-operation: all state returns to reset values next edge; in-flight responses arriving after reset deasserts are not discarded (imem must be reset together).

## Configuration
- FETCH_BYPASS_EN defined: when FIFO empty, !stallD, !FlushD, !PcSrcE and an accepted (non-discarded) response arrives, it loads IF/ID directly, bypassing the FIFO.
- Undefined: every response passes through the FIFO (one extra cycle); no bypass mux.

## Structure
- Shared package core_pkg: XLEN, NOP_INSTR (32'h0000_0013), RESET_PC default.
- One sub-module: fetch_fifo (synchronous DEPTH-entry FIFO, push/pop/clear, count output, DEPTH power of 2, pointer wrap by natural overflow).

## Test plan
- Reset released, imem latency 1, no stalls → imem_addr 0,4,8…; InstrD sequence matches memory, validD=1 continuously from steady state, PCPlus4D=PCD+4.
- stallF=stallD=1 for 3 cycles with 2 requests outstanding → imem_req=0, FIFO fills to 2, InstrD held; release → words 0x8,0xC delivered in order, none lost.
- PcSrcE=1, PCTargetE=0x100 with 2 outstanding → both responses dropped, next imem_addr=0x100, first validD=1 instruction has PCD=0x100.
- FlushD=1 and stallD=1 same cycle → InstrD=0x00000013, validD=0 next cycle.
- Variable latency 1–4 cycles, random stalls/redirects, 10k cycles → scoreboard: PCD sequence equals architectural fetch order, never > DEPTH outstanding.
- Reset asserted while FIFO holds 2 entries → next cycle validD=0, InstrD=NOP, imem_addr=RESET_PC, imem_req=0.
